// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the sequential ALU: the opcode and FSM state encodings, the
// status flag bundle, and a small helper that identifies the ops that are
// served by the iterative divider.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcode encoding, kept compatible with the earlier 4-bit combinational ALU.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NAND = 4'd7,
    OP_NOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_MOD  = 4'd10,
    OP_SHL  = 4'd11,
    OP_SHR  = 4'd12,
    OP_ASR  = 4'd13,
    OP_ROL  = 4'd14,
    OP_ILL  = 4'd15
  } alu_op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Status flags registered alongside every result.
  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic dz;
    logic ill;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = 5'b00000;

  // DIV and MOD share the divider; both return quotient and remainder.
  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// -----------------------------------------------------------------------------
// alu_seq_divider
// Restoring unsigned divider, one quotient bit per cycle. The first step is
// taken on the start edge itself, so done pulses exactly WIDTH cycles after
// start and quotient/remainder are valid while done is high (and held after).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset, clears all state
//   start      in   load operands and take the first step
//   dividend   in   WIDTH  numerator (sampled with start)
//   divisor    in   WIDTH  denominator (sampled with start, must be non-zero)
//   busy       out  iterations still pending after the start edge
//   done       out  one-cycle pulse, results valid
//   quotient   out  WIDTH
//   remainder  out  WIDTH
// -----------------------------------------------------------------------------
module alu_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*WIDTH-1:0] step_s;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract when it fits, and shift the quotient bit into quo.
  // quo starts as the dividend and is consumed MSB-first as it fills.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] trial;
    logic           qbit;
    trial = {rem, quo[WIDTH-1]};
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      qbit  = 1'b1;
    end else begin
      qbit  = 1'b0;
    end
    return {trial[WIDTH-1:0], quo[WIDTH-2:0], qbit};
  endfunction

  // Step operands come straight from the ports on the start edge.
  always_comb begin
    if (start) begin
      step_s = div_step({WIDTH{1'b0}}, dividend, divisor);
    end else begin
      step_s = div_step(rem_q, quo_q, dvs_q);
    end
  end

  // Next-state: load on start, iterate while busy, pulse done on last step.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      {rem_d, quo_d} = step_s;
      dvs_d  = divisor;
      cnt_d  = CNT_LOAD;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {rem_d, quo_d} = step_s;
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= {WIDTH{1'b0}};
      quo_q  <= {WIDTH{1'b0}};
      dvs_q  <= {WIDTH{1'b0}};
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked, parametrised ALU. Single-cycle ops are computed combinationally
// and registered on the accepting edge; DIV/MOD with a non-zero divisor go
// through the iterative divider. The registered result is held until the
// consumer accepts it, and a new request is only taken in IDLE.
//
// Ports:
//   clk, rst_n                 clock (rising) / synchronous active-low reset
//   in_valid, in_ready         request handshake (in_ready only in IDLE)
//   op [3:0], a, b             opcode and WIDTH-bit operands
//   out_valid, out_ready       result handshake
//   result_lo                  primary result / quotient
//   result_hi                  MUL high half / remainder, else 0
//   flag_zero/carry/ovf/dz/ill status flags for the held result
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dz,
  output logic             flag_ill
);

  localparam logic [WIDTH-1:0] W_L  = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  alu_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  alu_flags_t       flags_q, flags_d;

  alu_op_e          op_s;
  logic [WIDTH-1:0] sc_lo_s;
  logic [WIDTH-1:0] sc_hi_s;
  alu_flags_t       sc_flags_s;
  logic [WIDTH:0]   ext_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [SHW-1:0]   sh_amt_s;
  logic [WIDTH-1:0] rot_amt_s;
  logic             sh_in_range_s;
  logic             sh_eq_w_s;

  logic             div_start_s;
  logic             div_busy_s;
  logic             div_done_s;
  logic [WIDTH-1:0] div_quo_s;
  logic [WIDTH-1:0] div_rem_s;

  assign op_s          = alu_op_e'(op);
  assign sh_amt_s      = b[SHW-1:0];
  assign sh_in_range_s = (b < W_L);
  assign sh_eq_w_s     = (b == W_L);
  assign rot_amt_s     = b % W_L;

  // Single-cycle datapath. Shifts are done on a one-bit-extended operand so
  // the bit that falls off the end lands in the extension and becomes carry.
  // DIV/MOD here only covers the divide-by-zero result.
  always_comb begin
    sc_lo_s    = ZERO;
    sc_hi_s    = ZERO;
    sc_flags_s = FLAGS_CLEAR;
    ext_s      = {(WIDTH+1){1'b0}};
    prod_s     = {ZERO, a} * {ZERO, b};
    case (op_s)
      OP_ADD: begin
        ext_s            = {1'b0, a} + {1'b0, b};
        sc_lo_s          = ext_s[WIDTH-1:0];
        sc_flags_s.carry = ext_s[WIDTH];
        sc_flags_s.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_lo_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The borrow out of the extended subtraction is exactly a < b.
        ext_s            = {1'b0, a} - {1'b0, b};
        sc_lo_s          = ext_s[WIDTH-1:0];
        sc_flags_s.carry = ext_s[WIDTH];
        sc_flags_s.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_lo_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        sc_lo_s = prod_s[WIDTH-1:0];
        sc_hi_s = prod_s[2*WIDTH-1:WIDTH];
      end
      OP_DIV, OP_MOD: begin
        sc_lo_s       = ONES;
        sc_hi_s       = a;
        sc_flags_s.dz = 1'b1;
      end
      OP_AND:  sc_lo_s = a & b;
      OP_OR:   sc_lo_s = a | b;
      OP_XOR:  sc_lo_s = a ^ b;
      OP_NAND: sc_lo_s = ~(a & b);
      OP_NOR:  sc_lo_s = ~(a | b);
      OP_NOT:  sc_lo_s = ~a;
      OP_SHL: begin
        if (sh_in_range_s) begin
          ext_s            = {1'b0, a} << sh_amt_s;
          sc_lo_s          = ext_s[WIDTH-1:0];
          sc_flags_s.carry = ext_s[WIDTH];
        end else if (sh_eq_w_s) begin
          sc_flags_s.carry = a[0];
        end else begin
          sc_flags_s.carry = 1'b0;
        end
      end
      OP_SHR: begin
        if (sh_in_range_s) begin
          ext_s            = {a, 1'b0} >> sh_amt_s;
          sc_lo_s          = ext_s[WIDTH:1];
          sc_flags_s.carry = ext_s[0];
        end else if (sh_eq_w_s) begin
          sc_flags_s.carry = a[WIDTH-1];
        end else begin
          sc_flags_s.carry = 1'b0;
        end
      end
      OP_ASR: begin
        if (sh_in_range_s) begin
          ext_s            = $signed({a, 1'b0}) >>> sh_amt_s;
          sc_lo_s          = ext_s[WIDTH:1];
          sc_flags_s.carry = ext_s[0];
        end else if (sh_eq_w_s) begin
          sc_lo_s          = {WIDTH{a[WIDTH-1]}};
          sc_flags_s.carry = a[WIDTH-1];
        end else begin
          sc_lo_s          = {WIDTH{a[WIDTH-1]}};
          sc_flags_s.carry = 1'b0;
        end
      end
      OP_ROL: begin
        // The last bit rotated out of the MSB ends up in the LSB.
        sc_lo_s = (a << rot_amt_s) | (a >> (W_L - rot_amt_s));
        if ((b != ZERO) && (b <= W_L)) begin
          sc_flags_s.carry = sc_lo_s[0];
        end else begin
          sc_flags_s.carry = 1'b0;
        end
      end
      OP_ILL: sc_flags_s.ill = 1'b1;
      default: sc_flags_s.ill = 1'b1;
    endcase
    sc_flags_s.zero = (sc_lo_s == ZERO);
  end

  alu_seq_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start_s),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Control FSM next-state and result capture; outputs hold by default.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    flags_d     = flags_q;
    div_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_div_op(op_s) && (b != ZERO)) begin
            state_d     = ST_DIV;
            div_start_s = 1'b1;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            res_lo_d    = sc_lo_s;
            res_hi_d    = sc_hi_s;
            flags_d     = sc_flags_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          state_d      = ST_DONE;
          out_valid_d  = 1'b1;
          res_lo_d     = div_quo_s;
          res_hi_d     = div_rem_s;
          flags_d      = FLAGS_CLEAR;
          flags_d.zero = (div_quo_s == ZERO);
        end else if (!div_busy_s) begin
          // Divider idle without a done pulse: recover rather than hang.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      res_lo_q    <= ZERO;
      res_hi_q    <= ZERO;
      flags_q     <= FLAGS_CLEAR;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign result_lo  = res_lo_q;
  assign result_hi  = res_hi_q;
  assign flag_zero  = flags_q.zero;
  assign flag_carry = flags_q.carry;
  assign flag_ovf   = flags_q.ovf;
  assign flag_dz    = flags_q.dz;
  assign flag_ill   = flags_q.ill;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked ALU. It is the successor to the team's 4-bit combinational ALU and sits between the input switch/operand registers and the output display path. Features:
- Operand width is set by WIDTH.
- Results, including a full-width product/remainder high half, are registered with status flags.
- DIV/MOD run through an iterative one-bit-per-cycle divider.
- The result is held under output backpressure.

Parameters:
WIDTH, 8, operand and result-half width in bits (min 4).
SHW, $clog2(WIDTH), bits of b used as shift/rotate amount when b < WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  operation request valid.
in_ready  output  1  block can accept a request.
op  input  4  opcode (see Behaviour).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result_lo  output  WIDTH  primary result / quotient.
result_hi  output  WIDTH  MUL high half / DIV,MOD remainder; 0 otherwise.
flag_zero  output  1  result_lo == 0.
flag_carry  output  1  ADD carry-out / SUB borrow (a<b unsigned) / last bit shifted out; else 0.
flag_ovf  output  1  signed overflow on ADD/SUB; else 0.
flag_dz  output  1  DIV/MOD with b == 0.
flag_ill  output  1  opcode 15.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (unsigned, 2*WIDTH product), 3 DIV (unsigned), 4 AND, 5 OR, 6 XOR, 7 NAND, 8 NOR.
  - 9 NOT a (b ignored), 10 MOD (unsigned), 11 SHL, 12 SHR, 13 ASR, 14 ROL.
  - 15 illegal.
- States: IDLE, DIV, DONE.
- Reset (rst_n low at clk edge): state=IDLE; out_valid=0; all result and flag outputs = 0; divider cleared. Reset overrides everything, including an in-progress division or a held result.
- in_ready = 1 only in IDLE. A transfer occurs when in_valid & in_ready at a rising edge (cycle T); a, b and op are captured at that edge.
- Single-cycle ops (everything except DIV/MOD with b != 0):
  - Result and flags registered at edge T.
  - State goes to DONE; out_valid = 1 from T+1.
- DIV/MOD with b != 0:
  - State goes to DIV; divider runs exactly WIDTH cycles.
  - State goes to DONE; out_valid = 1 from T+WIDTH+1.
- DIV and MOD both produce quotient in result_lo and remainder in result_hi.
- Divide by zero: no iteration. result_lo = all ones, result_hi = a, flag_dz = 1; out_valid from T+1.
- DONE:
  - Outputs stable while out_ready = 0.
  - When out_valid & out_ready at an edge, state returns to IDLE, out_valid drops the next cycle, and the outputs keep their last value.
  - in_ready rises the cycle after the output handshake; there is no overlap.
  - Minimum throughput: one op per 2 cycles.
- Shift/rotate amount is b.
  - b >= WIDTH: SHL/SHR give 0; ASR gives WIDTH copies of a[WIDTH-1]; ROL uses b mod WIDTH.
  - flag_carry = last bit shifted out (0 if amount 0 or >= WIDTH+1).
- SUB: result_lo = a - b mod 2^WIDTH. flag_ovf = (a[msb] != b[msb]) & (res[msb] != a[msb]).
- ADD: flag_ovf = (a[msb] == b[msb]) & (res[msb] != a[msb]).
- Illegal op: results 0, flag_zero = 1, flag_ill = 1, latency 1.
- in_valid while in_ready = 0 is ignored; the requester must hold it.

Decomposition:
- Package alu_pkg:
  - opcode enum (OP_ADD..OP_ROL, OP_ILL = 15);
  - state enum;
  - flags struct {zero, carry, ovf, dz, ill}.
- Sub-module alu_seq_divider:
  - restoring unsigned divider, parameter WIDTH;
  - ports start, dividend, divisor, busy, done (1-cycle pulse), quotient, remainder;
  - WIDTH cycles start-to-done.
- Everything else is in alu_seq: FSM, combinational single-cycle datapath, output registers.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01 -> at T+1: out_valid=1, result_lo=0x00, flag_carry=1, flag_zero=1, flag_ovf=0.
- SUB a=0x80 b=0x01 -> result_lo=0x7F, flag_ovf=1, flag_carry=0. MUL a=0xFF b=0xFF -> result_hi=0xFE, result_lo=0x01.
- DIV a=200 b=7 -> in_ready=0 during T+1..T+8; out_valid first at T+9; result_lo=28, result_hi=4.
- MOD a=0x2A b=0 -> at T+1: result_lo=0xFF, result_hi=0x2A, flag_dz=1. Opcode 15 -> flag_ill=1, result 0.
- ASR a=0x90 b=9 -> result_lo=0xFF.
- Backpressure: hold out_ready=0 for 5 cycles -> outputs unchanged and in_ready=0; then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-DIV (rst_n=0 at T+4) -> next cycle state IDLE, out_valid=0, outputs 0. A following ADD 3+4 gives 7 at latency 1.
